muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 59 +++++
 rtl/muldiv_cache.sv | 57 +++++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Op/kind encodings, FSM states and op decode helpers shared
//               by the multiply/divide unit and its result cache.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [2:0] c_op_mul    = 3'd0;
    localparam logic [2:0] c_op_mulh   = 3'd1;
    localparam logic [2:0] c_op_mulhsu = 3'd2;
    localparam logic [2:0] c_op_mulhu  = 3'd3;
    localparam logic [2:0] c_op_div    = 3'd4;
    localparam logic [2:0] c_op_divu   = 3'd5;
    localparam logic [2:0] c_op_rem    = 3'd6;
    localparam logic [2:0] c_op_remu   = 3'd7;

    typedef enum logic [2:0] {
        KIND_MUL_SS = 3'd0,
        KIND_MUL_SU = 3'd1,
        KIND_MUL_UU = 3'd2,
        KIND_DIV_S  = 3'd3,
        KIND_DIV_U  = 3'd4
    } kind_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DIV   = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // The low product half is sign-agnostic, so a plain mul is filed as unsigned.
    function automatic kind_t op_kind(input logic [2:0] op);
        case (op)
            c_op_mulh:            return KIND_MUL_SS;
            c_op_mulhsu:          return KIND_MUL_SU;
            c_op_mul, c_op_mulhu: return KIND_MUL_UU;
            c_op_div, c_op_rem:   return KIND_DIV_S;
            default:              return KIND_DIV_U;
        endcase
    endfunction

    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == c_op_mulh) || (op == c_op_mulhsu) || (op == c_op_div) || (op == c_op_rem);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == c_op_mulh) || (op == c_op_div) || (op == c_op_rem);
    endfunction

    function automatic logic is_mul_kind(input kind_t k);
        return (k == KIND_MUL_SS) || (k == KIND_MUL_SU) || (k == KIND_MUL_UU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_cache.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_cache
// Description : One-entry result cache tagged by {a, b, kind}; holds the full
//               product or the {remainder, quotient} pair.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_cache
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    input  logic [2:0]        i_op,
    input  logic              i_we,
    input  logic [XLEN-1:0]   i_wr_a,
    input  logic [XLEN-1:0]   i_wr_b,
    input  kind_t             i_wr_kind,
    input  logic [2*XLEN-1:0] i_wr_data,
    output logic              o_hit,
    output logic [2*XLEN-1:0] o_data
);

    logic              r_valid;
    logic [XLEN-1:0]   r_tag_a;
    logic [XLEN-1:0]   r_tag_b;
    kind_t             r_tag_kind;
    logic [2*XLEN-1:0] r_data;
    logic              w_kind_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_tag_a    <= '0;
            r_tag_b    <= '0;
            r_tag_kind <= KIND_MUL_SS;
            r_data     <= '0;
        end else if (i_we) begin
            r_valid    <= 1'b1;
            r_tag_a    <= i_wr_a;
            r_tag_b    <= i_wr_b;
            r_tag_kind <= i_wr_kind;
            r_data     <= i_wr_data;
        end
    end

    // Any stored product carries the low half that a plain mul needs.
    assign w_kind_ok = (r_tag_kind == op_kind(i_op)) ||
                       ((i_op == c_op_mul) && is_mul_kind(r_tag_kind));
    assign o_hit     = r_valid && (r_tag_a == i_a) && (r_tag_b == i_b) && w_kind_ok;
    assign o_data    = r_data;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply (MUL_BITS per cycle) / restoring divide
//               unit with a one-entry result cache and pipeline stall output.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            busy,
    output logic            stall
);

    localparam int              c_cnt_w      = $clog2(XLEN) + 1;
    localparam int              c_mul_cycles = XLEN / MUL_BITS;
    localparam logic [XLEN-1:0] c_min        = {1'b1, {(XLEN-1){1'b0}}};

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_a, r_b;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [2*XLEN-1:0]   r_acc, r_mcand;
    logic [XLEN-1:0]     r_mplier, r_quo, r_rem, r_divisor, r_result;
    logic                r_neg, r_rneg;

    logic                w_accept, w_sa, w_sb, w_div0, w_ovf, w_hit, w_cache_we;
    logic [XLEN-1:0]     w_mag_a, w_mag_b, w_special_res, w_quo_f, w_rem_f;
    logic [2*XLEN-1:0]   w_pp, w_prod, w_fix_data, w_cache_data;
    logic [XLEN:0]       w_rem_shift, w_rem_diff;

    // mul and div return the low half / quotient; everything else the high half / remainder.
    function automatic logic [XLEN-1:0] sel_half(input logic [2:0] o, input logic [2*XLEN-1:0] d);
        return ((o == c_op_mul) || (o == c_op_div) || (o == c_op_divu)) ? d[XLEN-1:0] : d[2*XLEN-1:XLEN];
    endfunction

    assign w_accept      = start && !flush;
    assign w_sa          = op_signed_a(op) && a[XLEN-1];
    assign w_sb          = op_signed_b(op) && b[XLEN-1];
    assign w_mag_a       = w_sa ? -a : a;
    assign w_mag_b       = w_sb ? -b : b;
    assign w_div0        = op[2] && (b == '0);
    assign w_ovf         = op[2] && op_signed_b(op) && (a == c_min) && (b == '1);
    assign w_special_res = w_div0 ? (op[1] ? a : '1) : (op[1] ? '0 : c_min);

    assign w_pp        = r_mcand * {{(2*XLEN-MUL_BITS){1'b0}}, r_mplier[MUL_BITS-1:0]};
    assign w_rem_shift = {r_rem, r_quo[XLEN-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_divisor};

    assign w_prod      = r_neg ? -r_acc : r_acc;
    assign w_quo_f     = r_neg ? -r_quo : r_quo;
    assign w_rem_f     = r_rneg ? -r_rem : r_rem;
    assign w_fix_data  = r_op[2] ? {w_rem_f, w_quo_f} : w_prod;
    assign w_cache_we  = (r_state == S_FIXUP) && !flush;

    muldiv_cache #(.XLEN(XLEN)) u_cache (
        .clk       (sys_clk),
        .rst       (rst),
        .i_a       (a),
        .i_b       (b),
        .i_op      (op),
        .i_we      (w_cache_we),
        .i_wr_a    (r_a),
        .i_wr_b    (r_b),
        .i_wr_kind (op_kind(r_op)),
        .i_wr_data (w_fix_data),
        .o_hit     (w_hit),
        .o_data    (w_cache_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_hit || w_div0 || w_ovf) w_state_nxt = S_DONE;
                    else if (op[2])               w_state_nxt = S_DIV;
                    else                          w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (flush)                                      w_state_nxt = S_IDLE;
                else if (r_cnt == c_cnt_w'(c_mul_cycles - 1))   w_state_nxt = S_FIXUP;
            end
            S_DIV: begin
                if (flush)                                      w_state_nxt = S_IDLE;
                else if (r_cnt == c_cnt_w'(XLEN - 1))           w_state_nxt = S_FIXUP;
            end
            S_FIXUP: w_state_nxt = flush ? S_IDLE : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg     <= 1'b0;
            r_rneg    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= op;
                        r_a       <= a;
                        r_b       <= b;
                        r_cnt     <= '0;
                        r_neg     <= w_sa ^ w_sb;
                        r_rneg    <= w_sa;
                        r_acc     <= '0;
                        r_mcand   <= {{XLEN{1'b0}}, w_mag_a};
                        r_mplier  <= w_mag_b;
                        r_quo     <= w_mag_a;
                        r_rem     <= '0;
                        r_divisor <= w_mag_b;
                        if (w_div0 || w_ovf) r_result <= w_special_res;
                        else if (w_hit)      r_result <= sel_half(op, w_cache_data);
                    end
                end
                S_MUL: begin
                    r_acc    <= r_acc + w_pp;
                    r_mcand  <= r_mcand << MUL_BITS;
                    r_mplier <= r_mplier >> MUL_BITS;
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                end
                S_DIV: begin
                    // Restore on a negative trial difference; the borrow is the inverted quotient bit.
                    r_rem <= w_rem_diff[XLEN] ? w_rem_shift[XLEN-1:0] : w_rem_diff[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], ~w_rem_diff[XLEN]};
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
                S_FIXUP: begin
                    if (!flush) r_result <= sel_half(r_op, w_fix_data);
                end
                default: ;
            endcase
        end
    end

    assign result       = r_result;
    assign result_valid = (r_state == S_DONE);
    assign busy         = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIXUP);
    assign stall        = ((r_state == S_IDLE) && w_accept) || busy;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed and randomized bench for muldiv_unit against an
//               arithmetic reference model with a one-entry cache model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int XLEN     = 32;
    localparam int MUL_BITS = 4;

    logic        sys_clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic        result_valid, busy, stall;

    muldiv_unit #(.XLEN(XLEN), .MUL_BITS(MUL_BITS)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .start        (start),
        .flush        (flush),
        .op           (op),
        .a            (a),
        .b            (b),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .stall        (stall)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Current-op expectation: start cycle, latency, value, and kill cycle (-1 = none)
    bit          x_live = 1'b0;
    bit          x_rst  = 1'b0;
    int          x_t, x_lat, x_kill, x_end;
    logic [31:0] x_val;
    logic [31:0] exp_result = '0;
    logic        e_valid, e_busy, e_stall;

    // Cache model
    bit          mc_valid = 1'b0;
    logic [31:0] mc_a, mc_b;
    int          mc_kind;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        longint          sa, sb, q;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = {32'b0, av};
        ub = {32'b0, bv};
        case (o)
            3'd0: begin p = ua * ub;          return p[31:0];  end
            3'd1: begin p = sa * sb;          return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;          return p[63:32]; end
            3'd4, 3'd6: begin
                if (bv == 32'd0) return (o == 3'd4) ? 32'hFFFFFFFF : av;
                if (av == 32'h80000000 && bv == 32'hFFFFFFFF) return (o == 3'd4) ? 32'h80000000 : 32'd0;
                q = (o == 3'd4) ? sa / sb : sa % sb;
                return q[31:0];
            end
            default: begin
                if (bv == 32'd0) return (o == 3'd5) ? 32'hFFFFFFFF : av;
                p = (o == 3'd5) ? ua / ub : ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    // 0 MUL_SS, 1 MUL_SU, 2 MUL_UU, 3 DIV_S, 4 DIV_U
    function automatic int kind_of(input logic [2:0] o);
        case (o)
            3'd1:       return 0;
            3'd2:       return 1;
            3'd0, 3'd3: return 2;
            3'd4, 3'd6: return 3;
            default:    return 4;
        endcase
    endfunction

    function automatic void predict(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                                    output int lat, output logic [31:0] val, output bit cacheable);
        val = ref_result(o, av, bv);
        cacheable = 1'b0;
        if (o >= 3'd4 && (bv == 32'd0 ||
            ((o == 3'd4 || o == 3'd6) && av == 32'h80000000 && bv == 32'hFFFFFFFF)))
            lat = 1;
        else if (mc_valid && mc_a == av && mc_b == bv &&
                 (mc_kind == kind_of(o) || (o == 3'd0 && mc_kind <= 2)))
            lat = 1;
        else begin
            lat = (o < 3'd4) ? XLEN / MUL_BITS + 2 : XLEN + 2;
            cacheable = 1'b1;
        end
    endfunction

    always @(negedge sys_clk) begin
        if (chk_en) begin
            if (x_live && x_rst && cyc == x_kill + 1) exp_result = '0;
            if (x_live && cyc >= x_t && cyc <= x_end) begin
                e_valid = (x_kill < 0) && (cyc == x_t + x_lat);
                e_busy  = (cyc > x_t) && !e_valid;
                e_stall = !e_valid;
                if (e_valid) exp_result = x_val;
            end else begin
                e_valid = 1'b0;
                e_busy  = 1'b0;
                e_stall = start && !flush;
            end
            check("result_valid", 32'(result_valid), 32'(e_valid));
            check("busy",         32'(busy),         32'(e_busy));
            check("stall",        32'(stall),        32'(e_stall));
            check("result",       result,            exp_result);
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input bit lit, input int lit_lat, input logic [31:0] lit_val,
                          input int kill_off, input bit kill_rst, input bit flush_done);
        int          lat;
        logic [31:0] val;
        bit          cacheable;
        predict(o, av, bv, lat, val, cacheable);
        if (lit) begin
            lat = lit_lat;
            val = lit_val;
        end
        @(posedge sys_clk); #1;
        start = 1'b1; flush = 1'b0; op = o; a = av; b = bv;
        x_t = cyc; x_lat = lat; x_val = val; x_rst = kill_rst;
        x_kill = (kill_off > 0) ? cyc + kill_off : -1;
        x_end  = (kill_off > 0) ? x_kill : cyc + lat;
        x_live = 1'b1;
        if (kill_off > 0) begin
            repeat (kill_off) @(posedge sys_clk);
            #1;
            if (kill_rst) begin
                rst = 1'b1;
                @(posedge sys_clk);
                @(posedge sys_clk); #1;
                rst = 1'b0; start = 1'b0;
                mc_valid = 1'b0;
            end else begin
                flush = 1'b1; start = 1'b0;
                @(posedge sys_clk); #1;
                flush = 1'b0;
            end
        end else begin
            repeat (lat) @(posedge sys_clk);
            #1;
            if (flush_done) flush = 1'b1;
            if (cacheable) begin
                mc_valid = 1'b1; mc_a = av; mc_b = bv; mc_kind = kind_of(o);
            end
        end
    endtask

    task automatic gap(input int n, input bit start_flush);
        repeat (n) begin
            @(posedge sys_clk); #1;
            start = start_flush; flush = start_flush;
            op = 3'($urandom); a = $urandom; b = $urandom;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 20));
            6: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  r_o;
    logic [31:0] r_av, r_bv, r_val;
    int          r_lat, r_koff;
    bit          r_krst, r_cacheable;

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge sys_clk);
        #1 chk_en = 1'b1;
        @(posedge sys_clk); #1;
        rst = 1'b0;
        gap(1, 1'b0);

        // mulhu then mul on the same operands: second one served from the cache
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 10, 32'hFFFFFFFE, 0, 0, 0);
        run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1,  32'h00000001, 0, 0, 0);
        gap(1, 1'b0);
        // div/rem pair hits, remu is a different kind and misses
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1, 34, 32'hFFFFFFFD, 0, 0, 0);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 1, 1,  32'hFFFFFFFF, 0, 0, 0);
        run_op(3'd7, 32'hFFFFFFF9, 32'd2, 1, 34, 32'h00000001, 0, 0, 0);
        // special cases complete in one cycle and are not cached
        run_op(3'd5, 32'd5, 32'd0, 1, 1, 32'hFFFFFFFF, 0, 0, 0);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1, 1, 32'd0, 0, 0, 0);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1, 1, 32'd0, 0, 0, 0);
        run_op(3'd0, 32'h80000000, 32'hFFFFFFFF, 1, 10, 32'h80000000, 0, 0, 0);
        run_op(3'd1, 32'd5, 32'd0, 1, 10, 32'd0, 0, 0, 0);
        // start with flush in idle is not accepted
        gap(2, 1'b1);
        // flushed div, then the repeat takes full latency
        run_op(3'd4, 32'd100, 32'd7, 1, 34, 32'd14, 5, 0, 0);
        run_op(3'd4, 32'd100, 32'd7, 1, 34, 32'd14, 0, 0, 0);
        // reset during MUL clears outputs and the cache
        run_op(3'd3, 32'd1234, 32'd5678, 1, 10, 32'd0, 3, 1, 0);
        run_op(3'd4, 32'd100, 32'd7, 1, 34, 32'd14, 0, 0, 0);
        // mulhsu, flush during DONE has no effect, then a cache hit
        run_op(3'd2, 32'hFFFFFFFE, 32'd3, 1, 10, 32'hFFFFFFFF, 0, 0, 1);
        run_op(3'd2, 32'hFFFFFFFE, 32'd3, 1, 1,  32'hFFFFFFFF, 0, 0, 0);
        gap(1, 1'b0);

        r_av = pick();
        r_bv = pick();
        for (int i = 0; i < 160; i++) begin
            r_o = 3'($urandom);
            if ($urandom_range(0, 99) < 45) begin
                r_av = pick();
                r_bv = pick();
            end
            predict(r_o, r_av, r_bv, r_lat, r_val, r_cacheable);
            r_koff = 0;
            r_krst = 1'b0;
            if (r_lat > 1 && $urandom_range(0, 9) == 0) begin
                r_koff = $urandom_range(1, r_lat - 1);
                r_krst = ($urandom_range(0, 3) == 0);
            end
            run_op(r_o, r_av, r_bv, 0, 0, 32'd0, r_koff, r_krst, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2), 1'($urandom_range(0, 1)));
        end
        gap(2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
